// File: rtl/spidergon_vc_out_port.sv
`default_nettype none
// ============================================================================
// Module      : spidergon_vc_out_port
// Description : Output-port stage of a Spidergon router. NUM_VC virtual
//               channels, each with its own FIFO. Downstream flow control is
//               credit-based. Flits are switched onto a single link under
//               per-flit round-robin VC arbitration.
//
// Ports       : clk, reset      - clock, synchronous active-high reset
//               in_flit/in_valid/in_vc - flit from crossbar and target VC
//               in_vc_ready     - per-VC "FIFO not full"
//               out_flit/out_valid/out_vc - registered link output
//               credit_return   - per-VC one-cycle credit pulse from downstream
//               vc_empty        - per-VC "FIFO empty"
//               err_overflow    - sticky: write to full VC or invalid VC
//               err_credit      - sticky: credit returned while credit full
//
// Option      : `define SPIDERGON_PKT_LOCK_EN to lock the port to a VC from a
//               head flit (type 01) until its tail flit (type 00) is sent.
//
// Revision    : 1.0 - initial release
// ============================================================================
module spidergon_vc_out_port #(
   parameter  int FLIT_DATA_WIDTH = 16,
   parameter  int NUM_VC          = 2,
   parameter  int VC_DEPTH        = 4,
   parameter  int CREDIT_INIT     = 4,
   localparam int FTW             = FLIT_DATA_WIDTH + 2,
   localparam int VCW             = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FTW-1:0]    in_flit,
   input  logic              in_valid,
   input  logic [VCW-1:0]    in_vc,
   output logic [NUM_VC-1:0] in_vc_ready,
   output logic [FTW-1:0]    out_flit,
   output logic              out_valid,
   output logic [VCW-1:0]    out_vc,
   input  logic [NUM_VC-1:0] credit_return,
   output logic [NUM_VC-1:0] vc_empty,
   output logic              err_overflow,
   output logic              err_credit
);

   localparam int PW  = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
   localparam int CW  = $clog2(VC_DEPTH + 1);
   localparam int CRW = (CREDIT_INIT > 1) ? $clog2(CREDIT_INIT + 1) : 1;

   // Round-robin step: (base + off) mod NUM_VC, with off < NUM_VC.
   function automatic logic [VCW-1:0] f_rr_idx(input logic [VCW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_VC) begin
         s = s - NUM_VC;
      end
      return VCW'(s);
   endfunction

   logic [NUM_VC-1:0]          w_full;
   logic [NUM_VC-1:0]          w_empty;
   logic [NUM_VC-1:0]          w_wr_hit;
   logic [NUM_VC-1:0]          w_has_credit;
   logic [NUM_VC-1:0]          w_credit_err;
   logic [NUM_VC-1:0]          w_eligible;
   logic [NUM_VC-1:0][FTW-1:0] w_head;
   logic                       w_grant_valid;
   logic [VCW-1:0]             w_grant_vc;
   logic                       w_wr_err;

   logic [VCW-1:0] rr_ptr_q, rr_ptr_d;
   logic [FTW-1:0] out_flit_q, out_flit_d;
   logic           out_valid_q, out_valid_d;
   logic [VCW-1:0] out_vc_q, out_vc_d;
   logic           err_overflow_q, err_overflow_d;
   logic           err_credit_q, err_credit_d;

   // -------------------------------------------------------------------------
   // Per-VC FIFO and credit counter
   // -------------------------------------------------------------------------
   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      logic [FTW-1:0] mem_q [VC_DEPTH];
      logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
      logic [CW-1:0]  count_q, count_d;
      logic [CRW-1:0] credit_q, credit_d;
      logic           w_push;
      logic           w_pop;

      assign w_full[v]       = (count_q == CW'(VC_DEPTH));
      assign w_empty[v]      = (count_q == '0);
      assign w_wr_hit[v]     = in_valid && (in_vc == VCW'(v));
      // Readiness is purely ~full: a same-cycle pop never frees a slot early.
      assign w_push          = w_wr_hit[v] && !w_full[v];
      assign w_pop           = w_grant_valid && (w_grant_vc == VCW'(v));
      assign w_has_credit[v] = (credit_q != '0);
      assign w_head[v]       = mem_q[rd_ptr_q];
      // A return that coincides with a send is absorbed and never overflows.
      assign w_credit_err[v] = credit_return[v] && !w_pop &&
                               (credit_q == CRW'(CREDIT_INIT));

      always_comb begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         count_d  = count_q;
         credit_d = credit_q;
         if (w_push) begin
            wr_ptr_d = (wr_ptr_q == PW'(VC_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(VC_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         case ({w_pop, credit_return[v]})
            2'b10:   credit_d = credit_q - 1'b1;
            2'b01: begin
               if (credit_q != CRW'(CREDIT_INIT)) begin
                  credit_d = credit_q + 1'b1;
               end
            end
            default: credit_d = credit_q;
         endcase
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= CRW'(CREDIT_INIT);
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
         end
      end

      // Storage needs no reset: occupancy alone defines valid entries.
      always_ff @(posedge clk) begin
         if (w_push) begin
            mem_q[wr_ptr_q] <= in_flit;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Eligibility, with optional packet lock
   // -------------------------------------------------------------------------
`ifdef SPIDERGON_PKT_LOCK_EN
   typedef enum logic [0:0] {
      LK_FREE = 1'b0,
      LK_HELD = 1'b1
   } lock_state_e;

   lock_state_e    lock_state_q, lock_state_d;
   logic [VCW-1:0] lock_vc_q, lock_vc_d;
   logic [1:0]     w_grant_type;

   assign w_grant_type = w_head[w_grant_vc][FTW-1 -: 2];

   always_comb begin
      lock_state_d = lock_state_q;
      lock_vc_d    = lock_vc_q;
      if (w_grant_valid) begin
         if (w_grant_type == 2'b01) begin
            lock_state_d = LK_HELD;
            lock_vc_d    = w_grant_vc;
         end else if (w_grant_type == 2'b00) begin
            lock_state_d = LK_FREE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_state_q <= LK_FREE;
         lock_vc_q    <= '0;
      end else begin
         lock_state_q <= lock_state_d;
         lock_vc_q    <= lock_vc_d;
      end
   end

   assign w_eligible = ~w_empty & w_has_credit &
                       ((lock_state_q == LK_HELD) ? (NUM_VC'(1) << lock_vc_q)
                                                  : {NUM_VC{1'b1}});
`else
   assign w_eligible = ~w_empty & w_has_credit;
`endif

   // -------------------------------------------------------------------------
   // Round-robin arbiter: first eligible VC at or after the pointer
   // -------------------------------------------------------------------------
   always_comb begin
      w_grant_valid = 1'b0;
      w_grant_vc    = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (!w_grant_valid && w_eligible[f_rr_idx(rr_ptr_q, i)]) begin
            w_grant_valid = 1'b1;
            w_grant_vc    = f_rr_idx(rr_ptr_q, i);
         end
      end
   end

   // -------------------------------------------------------------------------
   // Output register, pointer and sticky errors
   // -------------------------------------------------------------------------
   assign w_wr_err = in_valid && ((w_wr_hit == '0) || ((w_wr_hit & w_full) != '0));

   always_comb begin
      rr_ptr_d       = rr_ptr_q;
      out_valid_d    = w_grant_valid;
      out_flit_d     = out_flit_q;
      out_vc_d       = out_vc_q;
      err_overflow_d = err_overflow_q | w_wr_err;
      err_credit_d   = err_credit_q | (|w_credit_err);
      if (w_grant_valid) begin
         rr_ptr_d   = f_rr_idx(w_grant_vc, 1);
         out_flit_d = w_head[w_grant_vc];
         out_vc_d   = w_grant_vc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q       <= '0;
         out_valid_q    <= 1'b0;
         out_flit_q     <= '0;
         out_vc_q       <= '0;
         err_overflow_q <= 1'b0;
         err_credit_q   <= 1'b0;
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         out_valid_q    <= out_valid_d;
         out_flit_q     <= out_flit_d;
         out_vc_q       <= out_vc_d;
         err_overflow_q <= err_overflow_d;
         err_credit_q   <= err_credit_d;
      end
   end

   assign in_vc_ready  = ~w_full;
   assign vc_empty     = w_empty;
   assign out_flit     = out_flit_q;
   assign out_valid    = out_valid_q;
   assign out_vc       = out_vc_q;
   assign err_overflow = err_overflow_q;
   assign err_credit   = err_credit_q;

endmodule
`default_nettype wire
